// File: rtl/uart_tx_queue_if.sv
// Bundled LSU push/status and uart transmit signals for the UART transmit queue.
// master = core/uart side, slave = the queue itself.
interface uart_tx_queue_if;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        flush;
  logic        clr_err;
  logic        uart_is_transmitting;
  logic        uart_transmit;
  logic [7:0]  uart_tx_byte;
  logic [31:0] status;
  logic        full;
  logic        empty;
  logic [1:0]  dbg_state;

  // Handshake: a byte is taken on every clock where wr_en=1 (no ready; a
  // refused byte sets the sticky overflow flag). uart_transmit is a one-cycle
  // start pulse, acknowledged by uart_is_transmitting rising, and the frame
  // is complete when uart_is_transmitting falls.
  modport master (
    output wr_en, wr_data, flush, clr_err, uart_is_transmitting,
    input  uart_transmit, uart_tx_byte, status, full, empty, dbg_state
  );

  modport slave (
    input  wr_en, wr_data, flush, clr_err, uart_is_transmitting,
    output uart_transmit, uart_tx_byte, status, full, empty, dbg_state
  );
endinterface

// File: rtl/uart_tx_queue.sv
// UART transmit FIFO + sequencer feeding the uart transmit/tx_byte inputs.
// Define MINION_TX_CRLF_EN to expand each 0x0A into the pair 0x0D,0x0A.
module uart_tx_queue #(
  parameter int DEPTH         = 16,
  parameter int PTR_W         = 4,
  parameter int START_TIMEOUT = 15
) (
  input  logic            msoc_clk,
  input  logic            rstn,
  uart_tx_queue_if.slave  bus
);

  localparam int TMR_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } state_e;

  state_e           state_q;
  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             timeout_err_q, timeout_err_d;
  logic             transmit_q;
  logic [7:0]       tx_byte_q;
  logic [TMR_W-1:0] timer_q;

  logic       is_empty, is_full, busy;
  logic       launch, send_cr, pop, push, drop, timeout_evt;
  logic [7:0] head;

`ifdef MINION_TX_CRLF_EN
  logic crlf_pend_q;
`endif

  assign head     = mem_q[rd_ptr_q];
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == (PTR_W+1)'(DEPTH));
  assign busy     = (state_q != IDLE) || bus.uart_is_transmitting;

  // A flush cycle launches nothing, so the discarded head is never sent.
  assign launch = (state_q == IDLE) && !is_empty && !bus.uart_is_transmitting && !bus.flush;

`ifdef MINION_TX_CRLF_EN
  // The LF stays at the head while its CR goes out first.
  assign send_cr = (head == 8'h0A) && !crlf_pend_q;
`else
  assign send_cr = 1'b0;
`endif

  assign pop         = launch && !send_cr;
  assign push        = bus.wr_en && !bus.flush && (!is_full || pop);
  assign drop        = bus.wr_en && !bus.flush && is_full && !pop;
  assign timeout_evt = (state_q == START) && !bus.uart_is_transmitting &&
                       (timer_q == TMR_W'(START_TIMEOUT - 1));

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    overflow_d    = drop || (overflow_q && !bus.clr_err);
    timeout_err_d = timeout_evt || (timeout_err_q && !bus.clr_err);
    if (bus.flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge msoc_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      transmit_q    <= 1'b0;
      tx_byte_q     <= 8'h00;
      timer_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef MINION_TX_CRLF_EN
      crlf_pend_q   <= 1'b0;
`endif
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      timeout_err_q <= timeout_err_d;
      transmit_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (launch) begin
            tx_byte_q  <= send_cr ? 8'h0D : head;
            transmit_q <= 1'b1;
            timer_q    <= '0;
            state_q    <= START;
          end
        end
        START: begin
          if (bus.uart_is_transmitting) begin
            state_q <= BUSY;
          end else if (timeout_evt) begin
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        BUSY: begin
          if (!bus.uart_is_transmitting) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
`ifdef MINION_TX_CRLF_EN
      if (bus.flush)   crlf_pend_q <= 1'b0;
      else if (launch) crlf_pend_q <= send_cr;
`endif
    end
  end

  assign bus.uart_transmit = transmit_q;
  assign bus.uart_tx_byte  = tx_byte_q;
  assign bus.full          = is_full;
  assign bus.empty         = is_empty;
  assign bus.dbg_state     = state_q;
  assign bus.status        = {16'h0000, 8'(count_q), overflow_q, timeout_err_q,
                              busy, is_full, is_empty, 3'b000};

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: expected uart bytes are queued as pushes
// are issued and popped by a monitor on every uart_transmit pulse.
module tb_uart_tx_queue;
  localparam int DEPTH = 16;

  logic msoc_clk = 1'b0;
  logic rstn     = 1'b0;

  uart_tx_queue_if ifc ();

  uart_tx_queue #(.DEPTH(DEPTH), .PTR_W(4), .START_TIMEOUT(15)) dut (
    .msoc_clk (msoc_clk),
    .rstn     (rstn),
    .bus      (ifc)
  );

  // clock / reset
  always #5 msoc_clk = ~msoc_clk;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;
  bit uart_hold = 1'b0;
  bit uart_dead = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge msoc_clk);
    #1;
  endtask

  // Expected uart bytes for one pushed byte.
  task automatic exp_add(input logic [7:0] b);
`ifdef MINION_TX_CRLF_EN
    if (b == 8'h0A) exp_q.push_back(8'h0D);
`endif
    exp_q.push_back(b);
  endtask

  task automatic push(input logic [7:0] b, input bit accepted);
    ifc.wr_en   = 1'b1;
    ifc.wr_data = b;
    tick();
    ifc.wr_en   = 1'b0;
    if (accepted) exp_add(b);
  endtask

  function automatic logic [7:0] rnd_nolf();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == 8'h0A) b = 8'h0B;
    return b;
  endfunction

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (k < 2000 && !(exp_q.size() == 0 && ifc.status[5] == 1'b0 && ifc.empty)) begin
      tick();
      k++;
    end
    check({name, "_drain"}, 32'(k < 2000), 32'd1);
  endtask

  task automatic pulse_clr();
    ifc.clr_err = 1'b1;
    tick();
    ifc.clr_err = 1'b0;
  endtask

  // uart model: is_transmitting high for 10 cycles, one cycle after a pulse
  initial begin
    int ucnt;
    bit udly;
    ucnt = 0;
    udly = 1'b0;
    ifc.uart_is_transmitting = 1'b0;
    forever begin
      @(negedge msoc_clk);
      if (udly) begin
        udly = 1'b0;
        ucnt = 10;
      end else if (ucnt > 0) begin
        ucnt--;
      end
      if (ifc.uart_transmit && !uart_dead) udly = 1'b1;
      ifc.uart_is_transmitting = uart_hold || (ucnt > 0);
    end
  end

  // scoreboard monitor
  initial begin
    bit prev;
    prev = 1'b0;
    forever begin
      @(negedge msoc_clk);
      if (ifc.uart_transmit === 1'b1) begin
        n_pulses++;
        check("pulse_width", 32'(prev), 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got byte %h, expected no pulse", ifc.uart_tx_byte);
        end else begin
          check("tx_byte", 32'(ifc.uart_tx_byte), 32'(exp_q.pop_front()));
        end
      end
      prev = (ifc.uart_transmit === 1'b1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, c;
    logic [7:0] b1, b2, x;
    ifc.wr_en   = 1'b0;
    ifc.wr_data = 8'h00;
    ifc.flush   = 1'b0;
    ifc.clr_err = 1'b0;
    rstn        = 1'b0;
    repeat (3) tick();
    check("rst_status_in_reset", ifc.status, 32'h0000_0008);
    rstn = 1'b1;
    tick();
    check("rst_status", ifc.status, 32'h0000_0008);
    check("rst_empty", 32'(ifc.empty), 32'd1);
    check("rst_full", 32'(ifc.full), 32'd0);
    check("rst_transmit", 32'(ifc.uart_transmit), 32'd0);
    check("rst_tx_byte", 32'(ifc.uart_tx_byte), 32'd0);

    // three bytes in order
    p0 = n_pulses;
    push(8'h41, 1'b1);
    push(8'h42, 1'b1);
    push(8'h43, 1'b1);
    wait_idle("abc");
    check("abc_pulses", 32'(n_pulses - p0), 32'd3);
    check("abc_status", ifc.status, 32'h0000_0008);

    // overflow with the uart held busy
    uart_hold = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) push(rnd_nolf(), 1'b1);
    push(rnd_nolf(), 1'b0);
    check("ovf_full", 32'(ifc.full), 32'd1);
    check("ovf_status", ifc.status, 32'h0000_10B0);
    pulse_clr();
    check("ovf_clr_status", ifc.status, 32'h0000_1030);
    p0 = n_pulses;
    uart_hold = 1'b0;
    wait_idle("ovf");
    check("ovf_pulses", 32'(n_pulses - p0), 32'd16);

    // full FIFO: push in the same cycle as the pop
    uart_hold = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) push(rnd_nolf(), 1'b1);
    check("pp_full_status", ifc.status, 32'h0000_1030);
    p0 = n_pulses;
    uart_hold = 1'b0;
    tick();
    x = rnd_nolf();
    push(x, 1'b1);
    check("pp_status", ifc.status, 32'h0000_1030);
    check("pp_transmit", 32'(ifc.uart_transmit), 32'd1);
    wait_idle("pp");
    check("pp_pulses", 32'(n_pulses - p0), 32'd17);

    // start timeout; clr_err in the same cycle as a new timeout keeps the flag
    uart_dead = 1'b1;
    b1 = rnd_nolf();
    b2 = rnd_nolf();
    push(b1, 1'b1);
    push(b2, 1'b1);
    c = 0;
    while (ifc.uart_transmit !== 1'b1 && c < 50) begin
      tick();
      c++;
    end
    check("to_first_pulse", 32'(c < 50), 32'd1);
    c = 0;
    while (ifc.status[6] !== 1'b1 && c < 100) begin
      tick();
      c++;
    end
    check("to_latency", 32'(c), 32'd15);
    check("to_state_idle", 32'(ifc.dbg_state), 32'd0);
    tick();
    check("to_retry_pulse", 32'(ifc.uart_transmit), 32'd1);
    repeat (14) tick();
    ifc.clr_err = 1'b1;
    tick();
    ifc.clr_err = 1'b0;
    check("to_set_wins", ifc.status, 32'h0000_0048);
    pulse_clr();
    check("to_clr_status", ifc.status, 32'h0000_0008);
    uart_dead = 1'b0;
    tick();

    // flush while a frame is in flight
    p0 = n_pulses;
    for (int i = 0; i < 6; i++) push(rnd_nolf(), 1'b1);
    check("fl_count", 32'(ifc.status[15:8]), 32'd5);
    check("fl_state_busy", 32'(ifc.dbg_state), 32'd2);
    ifc.flush = 1'b1;
    tick();
    ifc.flush = 1'b0;
    exp_q.delete();
    check("fl_count_zero", 32'(ifc.status[15:8]), 32'd0);
    check("fl_empty", 32'(ifc.empty), 32'd1);
    check("fl_frame_continues", 32'(ifc.dbg_state), 32'd2);
    wait_idle("flush");
    check("fl_pulses", 32'(n_pulses - p0), 32'd1);

    // line feed
    p0 = n_pulses;
    push(8'h0A, 1'b1);
    wait_idle("lf");
`ifdef MINION_TX_CRLF_EN
    check("lf_pulses", 32'(n_pulses - p0), 32'd2);
`else
    check("lf_pulses", 32'(n_pulses - p0), 32'd1);
`endif

    // random traffic, paced so the FIFO never overflows
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) push(8'h0A, 1'b1);
      else push(8'($urandom_range(0, 255)), 1'b1);
      repeat ($urandom_range(14, 25)) tick();
    end
    wait_idle("rand");
    check("rand_status", ifc.status, 32'h0000_0008);

    // reset in the middle of a frame
    push(rnd_nolf(), 1'b1);
    push(rnd_nolf(), 1'b1);
    push(rnd_nolf(), 1'b1);
    c = 0;
    while (ifc.uart_transmit !== 1'b1 && c < 50) begin
      tick();
      c++;
    end
    rstn = 1'b0;
    #1;
    exp_q.delete();
    check("mrst_transmit", 32'(ifc.uart_transmit), 32'd0);
    check("mrst_tx_byte", 32'(ifc.uart_tx_byte), 32'd0);
    check("mrst_count", 32'(ifc.status[15:8]), 32'd0);
    check("mrst_state", 32'(ifc.dbg_state), 32'd0);
    repeat (3) tick();
    rstn = 1'b1;
    repeat (15) tick();
    check("mrst_status", ifc.status, 32'h0000_0008);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
